hazard_ctrl: RTL

- Generates the stall/flush controls consumed by the F/D, D/E, E/M and M/W pipeline registers of the 5-stage RV32 core.
- Generates the execute-stage operand-forwarding selects.
- Keeps its own scoreboard of in-flight destination registers, mirroring the pipeline.
- Runs a memory-wait FSM with timeout detection, plus stall/flush performance counters.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl_fwd_sel.sv | 25 ++
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RV32 pipeline hazard unit.
//   sb_entry_t : in-flight destination record held per pipeline stage
//   src_t      : execute-stage source operands tracked next to sb_E
//   fwd_sel_e  : execute operand-forwarding select encoding
//   hz_state_e : memory-wait FSM states
package riscv_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_wr;
    logic       mem_rd;
  } sb_entry_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
  } src_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle.
//   master : pipeline side, drives decode/execute/memory status, reads controls
//   slave  : hazard unit side, reads status, drives stall/flush/forward/counters
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             valid_D;
  logic [4:0]       rs1_D;
  logic [4:0]       rs2_D;
  logic             uses_rs1_D;
  logic             uses_rs2_D;
  logic [4:0]       rd_D;
  logic             reg_wr_D;
  logic             mem_rd_D;
  logic             br_taken_E;
  logic             mem_req_M;
  logic             mem_ready_M;
  logic             stall_pc;
  logic             stall_fd;
  logic             flush_fd;
  logic             stall_de;
  logic             flush_de;
  logic             stall_em;
  logic             flush_mw;
  logic [1:0]       fwd_a_E;
  logic [1:0]       fwd_b_E;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output valid_D, rs1_D, rs2_D, uses_rs1_D, uses_rs2_D, rd_D, reg_wr_D,
           mem_rd_D, br_taken_E, mem_req_M, mem_ready_M,
    input  stall_pc, stall_fd, flush_fd, stall_de, flush_de, stall_em,
           flush_mw, fwd_a_E, fwd_b_E, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  valid_D, rs1_D, rs2_D, uses_rs1_D, uses_rs2_D, rd_D, reg_wr_D,
           mem_rd_D, br_taken_E, mem_req_M, mem_ready_M,
    output stall_pc, stall_fd, flush_fd, stall_de, flush_de, stall_em,
           flush_mw, fwd_a_E, fwd_b_E, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one execute-stage source operand.
//   src/uses : source register and whether the instruction reads it
//   sb_m/sb_w: memory- and writeback-stage scoreboard entries
//   sel      : FWD_MEM beats FWD_WB beats FWD_RF; x0 never forwarded
module hazard_fwd_sel
  import riscv_pkg::*;
(
  input  logic [4:0] src,
  input  logic       uses,
  input  sb_entry_t  sb_m,
  input  sb_entry_t  sb_w,
  output fwd_sel_e   sel
);
  logic hit_m;
  logic hit_w;

  assign hit_m = uses & sb_m.valid & sb_m.reg_wr & (sb_m.rd != 5'd0) & (sb_m.rd == src);
  assign hit_w = uses & sb_w.valid & sb_w.reg_wr & (sb_w.rd != 5'd0) & (sb_w.rd == src);

  always_comb begin
    sel = FWD_RF;
    if (hit_m)      sel = FWD_MEM;
    else if (hit_w) sel = FWD_WB;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage RV32 core.
//   clk, reset : clock, asynchronous active-high reset
//   hz (slave) : decode/execute/memory status in; stall/flush controls,
//                execute forwarding selects, sticky mem_timeout and
//                stall/flush performance counters out
// Tracks in-flight destinations in a private scoreboard (sb_E/sb_M/sb_W)
// that advances with the pipeline registers it controls.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 32
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);
  localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

  sb_entry_t            sb_e, sb_m, sb_w, sb_d;
  src_t                 src_e, src_d;
  logic                 mem_stall, load_use;
  logic                 stall_pc, stall_fd, flush_fd, stall_de, flush_de;
  logic                 stall_em, flush_mw;
  hz_state_e            state;
  logic [WCNT_W-1:0]    wait_cnt, wait_nxt;
  logic                 timeout_q;
  logic [CNT_W-1:0]     stall_cnt, flush_cnt;
  fwd_sel_e             fwd_a, fwd_b;

  assign mem_stall = hz.mem_req_M & ~hz.mem_ready_M;

  assign load_use = hz.valid_D & sb_e.valid & sb_e.mem_rd & sb_e.reg_wr &
                    (sb_e.rd != 5'd0) &
                    ((hz.uses_rs1_D & (hz.rs1_D == sb_e.rd)) |
                     (hz.uses_rs2_D & (hz.rs2_D == sb_e.rd)));

  // Memory wait outranks a taken branch, which outranks load-use
  // (the killed consumer makes the load-use moot).
  always_comb begin
    stall_pc = 1'b0;
    stall_fd = 1'b0;
    flush_fd = 1'b0;
    stall_de = 1'b0;
    flush_de = 1'b0;
    stall_em = 1'b0;
    flush_mw = 1'b0;
    if (mem_stall) begin
      stall_pc = 1'b1;
      stall_fd = 1'b1;
      stall_de = 1'b1;
      stall_em = 1'b1;
      flush_mw = 1'b1;
    end else if (hz.br_taken_E) begin
      flush_fd = 1'b1;
      flush_de = 1'b1;
    end else if (load_use) begin
      stall_pc = 1'b1;
      stall_fd = 1'b1;
      flush_de = 1'b1;
    end
  end

  assign sb_d  = '{valid: hz.valid_D, rd: hz.rd_D, reg_wr: hz.reg_wr_D, mem_rd: hz.mem_rd_D};
  assign src_d = '{rs1: hz.rs1_D, rs2: hz.rs2_D, uses_rs1: hz.uses_rs1_D, uses_rs2: hz.uses_rs2_D};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_e  <= '0;
      sb_m  <= '0;
      sb_w  <= '0;
      src_e <= '0;
    end else if (mem_stall) begin
      sb_w  <= '0;
    end else begin
      sb_w <= sb_m;
      sb_m <= sb_e;
      if (flush_de) begin
        sb_e  <= '0;
        src_e <= '0;
      end else begin
        sb_e  <= sb_d;
        src_e <= src_d;
      end
    end
  end

  hazard_fwd_sel u_fwd_a (
    .src  (src_e.rs1),
    .uses (src_e.uses_rs1),
    .sb_m (sb_m),
    .sb_w (sb_w),
    .sel  (fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .src  (src_e.rs2),
    .uses (src_e.uses_rs2),
    .sb_m (sb_m),
    .sb_w (sb_w),
    .sel  (fwd_b)
  );

  // Count saturates at MAX_WAIT so a long wait cannot wrap back below it.
  always_comb begin
    wait_nxt = wait_cnt;
    if (state == IDLE)
      wait_nxt = WCNT_W'(1);
    else if (wait_cnt != WCNT_W'(MAX_WAIT))
      wait_nxt = wait_cnt + WCNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_stall) begin
            state    <= WAIT;
            wait_cnt <= wait_nxt;
            if (wait_nxt == WCNT_W'(MAX_WAIT)) timeout_q <= 1'b1;
          end
        end
        WAIT: begin
          if (hz.mem_ready_M) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (mem_stall) begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WCNT_W'(MAX_WAIT)) timeout_q <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pc) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_fd) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.stall_pc     = stall_pc;
  assign hz.stall_fd     = stall_fd;
  assign hz.flush_fd     = flush_fd;
  assign hz.stall_de     = stall_de;
  assign hz.flush_de     = flush_de;
  assign hz.stall_em     = stall_em;
  assign hz.flush_mw     = flush_mw;
  assign hz.fwd_a_E      = fwd_a;
  assign hz.fwd_b_E      = fwd_b;
  assign hz.mem_timeout  = timeout_q;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_count  = flush_cnt;
endmodule
